keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scan controller for a ROWS x COLS passive key matrix.
- Drives one column low at a time, waits a settle window, then samples the synchronised rows.
- Accepts a key only after it is seen as the sole pressed key on STABLE_SCANS consecutive scans; this is the debounce.
- Delivers key codes over a valid/ready handshake to the keyboard decode logic. It sits between the FPGA pins and the code consumer.

Parameters:
- ROWS, 4, number of matrix rows (row_in width).
- COLS, 4, number of matrix columns (col_out width).
- SETTLE_CYCLES, 16, wait cycles after each column change. Must be >= 2 to cover the synchroniser.
- STABLE_SCANS, 8, consecutive identical full scans needed to accept a press or a release. Must be >= 1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, scanning permitted.
- row_in, input, ROWS, raw active-low row lines, asynchronous to clk.
- col_out, output, COLS, active-low column drive; exactly one bit low while scanning, all ones otherwise.
- key_code, output, KEY_W, index of the accepted key = row*COLS + col.
- key_valid, output, 1, key_code holds an unconsumed press event.
- key_ready, input, 1, consumer accepts the event.
- key_pressed, output, 1, level: an accepted key is currently held.
- multi_key, output, 1, high for the scan following any EVAL that saw 2 or more keys.
- overrun, output, 1, sticky: a press event was dropped because key_valid was pending.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset values: every output register goes to 0, except col_out = all ones. FSM state = IDLE. Stability counter, candidate and the reported flag all clear.
- row_in passes through a 2-flop synchroniser before any use. Row bits are inverted so that 1 means pressed.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, EVAL.
  - IDLE: col_out all ones. Go to DRIVE with col=0 when enable=1.
  - DRIVE (1 cycle): col_out = ~(1<<col).
  - SETTLE: SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): OR the synced rows into a per-scan press map at column col. If col = COLS-1, go to EVAL; otherwise col++ and go to DRIVE.
  - EVAL (1 cycle): if enable=1, go to DRIVE with col=0; otherwise go to IDLE.
- Scan period = COLS*(SETTLE_CYCLES+2)+1 cycles (73 with defaults). The press map clears at the start of each scan.
- EVAL counts the pressed bits in the map (n):
  - n = 1: the code is the candidate. If it equals the previous candidate, the stability counter increments, saturating at STABLE_SCANS. Otherwise the counter is set to 1 and the candidate is replaced.
  - n = 0: the candidate becomes the "none" state, with the same counting rule.
  - n >= 2: set multi_key; clear the candidate to invalid and the counter to 0. No events are generated.
- Press event: counter reaches STABLE_SCANS on a key candidate and the reported flag is 0.
  - Set key_pressed and the reported flag.
  - If key_valid = 0: load key_code and set key_valid.
  - Otherwise: keep the old key_code and set overrun.
- Release: counter reaches STABLE_SCANS on "none". Clear key_pressed and the reported flag.
- Key change without release: a different key becomes stable while the reported flag is 1. This is a new press event.
- Handshake: the transfer completes on a cycle with key_valid & key_ready; key_valid drops the next cycle.
  - key_code is stable while key_valid = 1.
  - A press event in the same cycle as a transfer loads the new code and keeps key_valid = 1; overrun is not set.
- A multi-key scan does not change key_pressed or the reported flag.
- enable falling mid-scan: the current scan completes; IDLE is entered after EVAL.
- Reset mid-operation: immediate return to the reset values; any pending event is lost.
- Width rule: KEY_W = clog2(ROWS*COLS), minimum 1. The stability counter is clog2(STABLE_SCANS+1) bits.

Decomposition:
- keypad_pkg holds:
  - the state enum: IDLE, DRIVE, SETTLE, SAMPLE, EVAL;
  - a function for KEY_W;
  - a constant CANDIDATE_NONE.
- Sub-module key_sync: parameterised-width 2-flop synchroniser with asynchronous reset. It is instantiated on row_in.

Test Plan:
Parameters for all scenarios: ROWS=4, COLS=4, SETTLE_CYCLES=4, STABLE_SCANS=3 (scan period = 25 cycles).
1. Reset asserted mid-SETTLE -> col_out=4'b1111 and all other outputs 0 in the same cycle. After reset release with enable=1, first DRIVE shows col_out=4'b1110.
2. Hold row 2 pressed on col 1 with key_ready=1 -> at the 3rd EVAL: key_code=9, key_valid for 1 cycle, key_pressed=1. Release -> key_pressed=0 after the 3rd empty EVAL.
3. Key 9 bouncing, toggling every 20 cycles for 300 cycles -> key_valid never asserts and key_pressed stays 0.
4. key_ready=0; press/release key 9, then press key 5 -> key_code stays 9 with key_valid=1 and overrun=1. Raise key_ready -> key_valid drops the next cycle.
5. Press r0c0 and r3c3 together -> multi_key=1 after each EVAL, no key_valid. Release r3c3 -> key 0 is accepted after 3 scans.
6. Drop enable mid-scan -> col_out walks to 4'b0111, passes EVAL, then goes all ones. Scanning resumes at col_out=4'b1110 when enable returns.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the key matrix scan controller.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        EVAL   = 3'd4
    } state_e;

    // Debounce candidate: a scan result is either no key, one key, or unusable.
    typedef enum logic [1:0] {
        CAND_INVALID = 2'd0,
        CAND_NONE    = 2'd1,
        CAND_KEY     = 2'd2
    } cand_kind_e;

    localparam cand_kind_e CANDIDATE_NONE = CAND_NONE;

    function automatic int unsigned key_width(input int unsigned n_keys);
        return (n_keys > 1) ? $clog2(n_keys) : 1;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
module key_sync #(
    parameter int unsigned     WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning key matrix controller with scan-level debounce and a
// valid/ready key event output.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int unsigned ROWS          = 4,
    parameter  int unsigned COLS          = 4,
    parameter  int unsigned SETTLE_CYCLES = 16,
    parameter  int unsigned STABLE_SCANS  = 8,
    localparam int unsigned KEY_W         = key_width(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_pressed,
    output logic             multi_key,
    output logic             overrun
);

    localparam int unsigned NKEYS  = ROWS * COLS;
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES);
    localparam int unsigned CNT_W  = $clog2(STABLE_SCANS + 1);
    localparam int unsigned NCNT_W = $clog2(NKEYS + 1);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [NKEYS-1:0]   map_q, map_d;
    cand_kind_e         cand_kind_q, cand_kind_d;
    logic [KEY_W-1:0]   cand_code_q, cand_code_d;
    logic [CNT_W-1:0]   stab_q, stab_d;
    logic               reported_q, reported_d;
    logic [KEY_W-1:0]   rep_code_q, rep_code_d;
    logic [COLS-1:0]    col_out_q, col_out_d;
    logic [KEY_W-1:0]   key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_pressed_q, key_pressed_d;
    logic               multi_q, multi_d;
    logic               overrun_q, overrun_d;

    logic [ROWS-1:0]    rows_sync;
    logic [ROWS-1:0]    rows_pressed;
    logic [NKEYS-1:0]   spread;
    logic [NCNT_W-1:0]  hits;
    logic [KEY_W-1:0]   hit_idx;
    cand_kind_e         new_kind;
    logic [KEY_W-1:0]   new_code;
    logic               same;
    logic               reached;
    logic               press_evt;
    logic               xfer;

    key_sync #(
        .WIDTH   (ROWS),
        .RST_VAL ('1)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (row_in),
        .q_o   (rows_sync)
    );

    assign rows_pressed = ~rows_sync;

    // Place row r at bit r*COLS so a shift by the column lands it on its key index.
    for (genvar i = 0; i < NKEYS; i++) begin : g_spread
        if ((i % COLS) == 0) begin : g_row
            assign spread[i] = rows_pressed[i / COLS];
        end else begin : g_zero
            assign spread[i] = 1'b0;
        end
    end

    // Index of the set bit; only meaningful when exactly one key is in the map.
    for (genvar b = 0; b < KEY_W; b++) begin : g_idx
        logic [NKEYS-1:0] mask;
        for (genvar i = 0; i < NKEYS; i++) begin : g_mask
            assign mask[i] = 1'((i >> b) & 1);
        end
        assign hit_idx[b] = |(map_q & mask);
    end

    assign hits = NCNT_W'($countones(map_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            col_q         <= '0;
            settle_q      <= '0;
            map_q         <= '0;
            cand_kind_q   <= CAND_INVALID;
            cand_code_q   <= '0;
            stab_q        <= '0;
            reported_q    <= 1'b0;
            rep_code_q    <= '0;
            col_out_q     <= '1;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            multi_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            settle_q      <= settle_d;
            map_q         <= map_d;
            cand_kind_q   <= cand_kind_d;
            cand_code_q   <= cand_code_d;
            stab_q        <= stab_d;
            reported_q    <= reported_d;
            rep_code_q    <= rep_code_d;
            col_out_q     <= col_out_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
            multi_q       <= multi_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        settle_d      = settle_q;
        map_d         = map_q;
        cand_kind_d   = cand_kind_q;
        cand_code_d   = cand_code_q;
        stab_d        = stab_q;
        reported_d    = reported_q;
        rep_code_d    = rep_code_q;
        col_out_d     = col_out_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_pressed_d = key_pressed_q;
        multi_d       = multi_q;
        overrun_d     = overrun_q;
        new_kind      = CAND_INVALID;
        new_code      = '0;
        same          = 1'b0;
        reached       = 1'b0;
        press_evt     = 1'b0;
        xfer          = key_valid_q & key_ready;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = DRIVE;
                    col_d     = '0;
                    map_d     = '0;
                    col_out_d = ~COLS'(1);
                end
            end
            DRIVE: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
            SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            SAMPLE: begin
                map_d = map_q | (spread << col_q);
                if (col_q == COL_W'(COLS - 1)) begin
                    state_d = EVAL;
                end else begin
                    state_d   = DRIVE;
                    col_d     = col_q + COL_W'(1);
                    col_out_d = ~(COLS'(1) << col_d);
                end
            end
            EVAL: begin
                multi_d = (hits >= NCNT_W'(2));
                if (hits >= NCNT_W'(2)) begin
                    cand_kind_d = CAND_INVALID;
                    cand_code_d = '0;
                    stab_d      = '0;
                end else begin
                    new_kind = (hits == NCNT_W'(1)) ? CAND_KEY : CANDIDATE_NONE;
                    new_code = (hits == NCNT_W'(1)) ? hit_idx : '0;
                    same     = (cand_kind_q == new_kind) && (cand_code_q == new_code);
                    if (!same) begin
                        stab_d = CNT_W'(1);
                    end else if (stab_q != CNT_W'(STABLE_SCANS)) begin
                        stab_d = stab_q + CNT_W'(1);
                    end
                    cand_kind_d = new_kind;
                    cand_code_d = new_code;
                    // Only the scan that first hits the threshold counts, not the saturated tail.
                    reached = (stab_d == CNT_W'(STABLE_SCANS)) &&
                              (!same || (stab_q != CNT_W'(STABLE_SCANS)));
                    if (reached && (new_kind == CAND_KEY) &&
                        (!reported_q || (rep_code_q != new_code))) begin
                        press_evt = 1'b1;
                    end
                    if (reached && (new_kind == CANDIDATE_NONE)) begin
                        key_pressed_d = 1'b0;
                        reported_d    = 1'b0;
                    end
                end
                if (enable) begin
                    state_d   = DRIVE;
                    col_d     = '0;
                    map_d     = '0;
                    col_out_d = ~COLS'(1);
                end else begin
                    state_d   = IDLE;
                    col_out_d = '1;
                end
            end
            default: begin
                state_d   = IDLE;
                col_out_d = '1;
            end
        endcase

        // A transfer in the same cycle frees the slot for the new event.
        if (press_evt) begin
            key_pressed_d = 1'b1;
            reported_d    = 1'b1;
            rep_code_d    = new_code;
            if (!key_valid_q || xfer) begin
                key_code_d  = new_code;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            key_valid_d = 1'b0;
        end
    end

    assign col_out     = col_out_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign multi_key   = multi_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner: scan-level reference model of the
// debounce rules, a passive key matrix, and directed plus random key patterns.
module tb_keypad_scanner;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned STABLE = 3;
    localparam int unsigned PERIOD = COLS * (SETTLE + 2) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_pressed;
    logic        multi_key;
    logic        overrun;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    // Reference model state: trailing run of identical scan results.
    int hist_last;
    int run_len;
    bit reported;
    int rep_code;
    bit exp_pressed;
    bit exp_multi;
    bit exp_overrun;
    int exp_q[$];

    keypad_scanner #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .SETTLE_CYCLES (SETTLE),
        .STABLE_SCANS  (STABLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_pressed (key_pressed),
        .multi_key   (multi_key),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Passive matrix: a held key pulls its row low while its column is driven low.
    for (genvar r = 0; r < ROWS; r++) begin : g_matrix
        assign row_in[r] = ~|(keys[r*COLS +: COLS] & ~col_out);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist_last   = -3;
        run_len     = 0;
        reported    = 1'b0;
        rep_code    = 0;
        exp_pressed = 1'b0;
        exp_multi   = 1'b0;
        exp_overrun = 1'b0;
        exp_q.delete();
    endtask

    // One full scan seeing key set k: -2 = several keys, -1 = none, else key index.
    task automatic model_scan(input logic [15:0] k);
        int n;
        int res;
        n   = $countones(k);
        res = -1;
        if (n >= 2) begin
            res = -2;
        end else if (n == 1) begin
            for (int i = 0; i < 16; i++) begin
                if (((k >> i) & 16'd1) != 16'd0) res = i;
            end
        end
        exp_multi = (n >= 2);
        if (res == hist_last) begin
            run_len++;
        end else begin
            hist_last = res;
            run_len   = 1;
        end
        if (res >= 0 && run_len == STABLE && (!reported || rep_code != res)) begin
            exp_pressed = 1'b1;
            reported    = 1'b1;
            rep_code    = res;
            if (exp_q.size() != 0) exp_overrun = 1'b1;
            else exp_q.push_back(res);
        end
        if (res == -1 && run_len == STABLE) begin
            exp_pressed = 1'b0;
            reported    = 1'b0;
        end
    endtask

    task automatic run_scan(input logic [15:0] k);
        keys = k;
        repeat (PERIOD) @(posedge clk);
        #1;
        model_scan(k);
        check("key_pressed", 32'(key_pressed), 32'(exp_pressed));
        check("multi_key", 32'(multi_key), 32'(exp_multi));
        check("overrun", 32'(overrun), 32'(exp_overrun));
    endtask

    // Leaves the bench just after the first DRIVE edge, aligned to scan boundaries.
    task automatic do_reset(input logic ready_val);
        @(negedge clk);
        reset     = 1'b1;
        keys      = '0;
        enable    = 1'b1;
        key_ready = ready_val;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("first_drive_col", 32'(col_out), 32'h e);
    endtask

    initial begin
        logic [15:0] k;
        bit          saw;
        reset     = 1'b1;
        enable    = 1'b0;
        key_ready = 1'b1;
        keys      = '0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (!reset && key_valid && key_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event actual code=%0d expected no event at %0t",
                                 key_code, $time);
                    end else begin
                        check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        #2;
        check("reset_outputs", {col_out, key_code, key_valid, key_pressed, multi_key, overrun},
              32'h0f00);

        // Press key 9, release, press again, then reset in the middle of SETTLE.
        do_reset(1'b1);
        repeat (2) run_scan(16'h0200);
        check("valid_before_stable", 32'(key_valid), 32'd0);
        run_scan(16'h0200);
        check("valid_at_stable", 32'(key_valid), 32'd1);
        repeat (3) run_scan(16'h0000);
        repeat (3) run_scan(16'h0200);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {col_out, key_code, key_valid, key_pressed, multi_key, overrun}, 32'h0f00);

        // Bouncing key: no stable run, no event.
        do_reset(1'b1);
        saw = 1'b0;
        for (int j = 0; j < 15; j++) begin
            keys = (j % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (key_pressed) saw = 1'b1;
            end
        end
        keys = '0;
        repeat (3 * PERIOD) begin
            @(posedge clk);
            #1;
            if (key_pressed) saw = 1'b1;
        end
        check("bounce_pressed", 32'(saw), 32'd0);

        // Consumer stalled: second press overruns, old code held.
        do_reset(1'b0);
        repeat (3) run_scan(16'h0200);
        repeat (3) run_scan(16'h0000);
        repeat (3) run_scan(16'h0020);
        check("stall_code", 32'(key_code), 32'd9);
        check("stall_valid", 32'(key_valid), 32'd1);
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_after_xfer", 32'(key_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Two keys at once, then one released.
        do_reset(1'b1);
        repeat (3) run_scan(16'h8001);
        check("multi_no_valid", 32'(key_valid), 32'd0);
        repeat (3) run_scan(16'h0001);

        // Enable dropped mid-scan: scan finishes, then idle.
        do_reset(1'b1);
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("col2_drive", 32'(col_out), 32'h b);
        repeat (6) @(posedge clk);
        #1;
        check("col3_drive", 32'(col_out), 32'h 7);
        repeat (6) @(posedge clk);
        #1;
        check("eval_col", 32'(col_out), 32'h 7);
        @(posedge clk);
        #1;
        check("idle_col", 32'(col_out), 32'h f);
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold", 32'(col_out), 32'h f);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("resume_col", 32'(col_out), 32'h e);

        // Random key sequences against the model.
        do_reset(1'b1);
        k = '0;
        for (int seg = 0; seg < 40; seg++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 2) begin
                k = '0;
            end else if (sel == 2) begin
                k = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            end else if (sel >= 7 && $countones(k) == 1) begin
                k = k;
            end else begin
                k = 16'd1 << $urandom_range(0, 15);
            end
            repeat ($urandom_range(1, 5)) run_scan(k);
        end
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
